// File: rtl/vga_rom_scheduler.sv
// Shares one synchronous image ROM between the VGA display fetch and two
// round-robin game requesters, using four clock slots per pixel period.
module vga_rom_scheduler #(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 8,
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int DISP_SLOT   = 1,
    parameter logic [DATA_W-1:0] BG_COLOR = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_tick,
    input  logic              video_on,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic [1:0]        gnt,
    output logic [1:0]        rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid
);

    // Handshake: a requester holds req[i] with a stable address until gnt[i]
    // pulses; gnt[i] is the only acceptance. Exactly one rd_valid[i] pulse
    // follows two clocks later and cannot be stalled.

    localparam logic [1:0] DISP_SLOT_L = 2'(DISP_SLOT);

    logic              p_tick_d;
    logic [1:0]        slot;
    logic              rr_ptr;
    logic [ADDR_W-1:0] rom_addr_q;

    // First pipeline stage tag {disp, req0, req1}, plus out-of-image flag.
    logic              s1_disp;
    logic              s1_bg;
    logic [1:0]        s1_gnt;

    logic              pix_start;
    logic [31:0]       ix;
    logic [31:0]       iy;
    logic              in_image;
    logic [ADDR_W-1:0] disp_addr;

    logic              disp_turn;
    logic              disp_bg;
    logic              issue_en;
    logic [1:0]        gnt_c;
    logic [ADDR_W-1:0] addr_c;
    logic              rr_next;
    logic              winner;

    always_comb begin
        pix_start = p_tick & ~p_tick_d;
        ix        = 32'(pixel_x) >> SCALE_SHIFT;
        iy        = 32'(pixel_y) >> SCALE_SHIFT;
        in_image  = (ix < IMG_W) && (iy < IMG_H);
        disp_addr = ADDR_W'(iy * IMG_W + ix);
    end

    always_comb begin
        disp_turn = 1'b0;
        disp_bg   = 1'b0;
        issue_en  = 1'b0;
        gnt_c     = 2'b00;
        addr_c    = rom_addr_q;
        rr_next   = rr_ptr;
        winner    = 1'b0;
        // Combinational outputs stay quiet while reset is held.
        if (reset) begin
            if (slot == DISP_SLOT_L && video_on) begin
                disp_turn = 1'b1;
                if (in_image) begin
                    issue_en = 1'b1;
                    addr_c   = disp_addr;
                end else begin
                    disp_bg  = 1'b1;
                end
            end else if (req != 2'b00) begin
                if (req == 2'b11) begin
                    winner = rr_ptr;
                end else begin
                    winner = ~req[0];
                end
                issue_en = 1'b1;
                gnt_c    = winner ? 2'b10 : 2'b01;
                addr_c   = winner ? req1_addr : req0_addr;
                rr_next  = ~winner;
            end
        end
    end

    assign gnt      = gnt_c;
    assign rom_en   = issue_en;
    assign rom_addr = addr_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_tick_d   <= 1'b0;
            slot       <= 2'd0;
            rr_ptr     <= 1'b0;
            rom_addr_q <= '0;
            s1_disp    <= 1'b0;
            s1_bg      <= 1'b0;
            s1_gnt     <= 2'b00;
            rd_valid   <= 2'b00;
            rd_data    <= '0;
            pix_valid  <= 1'b0;
            pix_data   <= BG_COLOR;
        end else begin
            p_tick_d   <= p_tick;
            slot       <= pix_start ? 2'd0 : slot + 2'd1;
            rr_ptr     <= rr_next;
            rom_addr_q <= addr_c;
            s1_disp    <= disp_turn;
            s1_bg      <= disp_bg;
            s1_gnt     <= gnt_c;
            // ROM data for a read issued last cycle is present now.
            rd_valid   <= s1_gnt;
            if (s1_gnt != 2'b00) begin
                rd_data <= rom_data;
            end
            pix_valid  <= s1_disp;
            if (s1_disp) begin
                pix_data <= s1_bg ? BG_COLOR : rom_data;
            end
        end
    end

endmodule

// File: tb/tb_vga_rom_scheduler.sv
// Bench for vga_rom_scheduler: display-fetch vector table, hand-written
// contention/blanking/reset sequences and a randomized run against a reference model.
module tb_vga_rom_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p_tick = 1'b1;
  logic        video_on = 1'b0;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic [1:0]  req = 2'b00;
  logic [14:0] req0_addr = '0;
  logic [14:0] req1_addr = '0;
  logic [1:0]  gnt;
  logic [1:0]  rd_valid;
  logic [7:0]  rd_data;
  logic        rom_en;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic [7:0]  pix_data;
  logic        pix_valid;

  vga_rom_scheduler dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .req(req),
    .req0_addr(req0_addr), .req1_addr(req1_addr), .gnt(gnt),
    .rd_valid(rd_valid), .rd_data(rd_data), .rom_en(rom_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .pix_data(pix_data),
    .pix_valid(pix_valid)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Synchronous ROM whose contents are the low address byte
  always @(posedge clk) if (rom_en) rom_data <= rom_addr[7:0];

  // Staged inputs, applied 1 time unit after the next rising edge
  logic        nx_reset = 1'b0;
  logic        nx_video_on = 1'b0;
  logic [9:0]  nx_px = '0;
  logic [9:0]  nx_py = '0;
  logic [1:0]  nx_req = 2'b00;
  logic [14:0] nx_a0 = '0;
  logic [14:0] nx_a1 = '0;
  int          ptc = 0;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  typedef struct {
    int         due;
    bit         is_pix;
    logic [1:0] mask;
    logic [7:0] data;
  } exp_t;
  exp_t        exp_q[$];
  int          cyc = 0;
  int          anchor = 0;
  bit          prev_pt = 1'b0;
  bit          rrp = 1'b0;
  logic [14:0] last_addr = '0;
  logic [7:0]  m_pix = '0;
  logic [7:0]  m_rd = '0;
  logic [1:0]  m_gnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
  endtask

  task automatic check_cycle();
    int s, ix, iy, w;
    logic [1:0]  e_gnt, e_rv;
    logic        e_en, e_pv;
    logic [14:0] e_addr;
    exp_t        e;
    if (!reset) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_rom_en", rom_en, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_pix_data", pix_data, 8'h00);
      chk("rst_rd_data", rd_data, 0);
      exp_q.delete();
      rrp = 0; last_addr = '0; m_pix = '0; m_rd = '0; m_gnt = '0;
      prev_pt = 0;
      anchor = cyc + 1;
      cyc++;
      return;
    end
    s = (cyc - anchor) % 4;
    e_gnt = 2'b00; e_en = 0; e_addr = last_addr; e_rv = 2'b00; e_pv = 0;
    if (s == 1 && video_on) begin
      ix = int'(pixel_x) / 4;
      iy = int'(pixel_y) / 4;
      e.due = cyc + 2; e.is_pix = 1; e.mask = 2'b00;
      if (ix < 160 && iy < 120) begin
        e_en = 1;
        e_addr = 15'((iy * 160 + ix) % 32768);
        e.data = 8'(e_addr % 256);
      end else begin
        e.data = 8'h00;
      end
      exp_q.push_back(e);
    end else if (req != 2'b00) begin
      w = (req == 2'b11) ? int'(rrp) : (req[0] ? 0 : 1);
      e_gnt = (w == 1) ? 2'b10 : 2'b01;
      e_en = 1;
      e_addr = (w == 1) ? req1_addr : req0_addr;
      rrp = (w == 0);
      e.due = cyc + 2; e.is_pix = 0; e.mask = e_gnt; e.data = e_addr[7:0];
      exp_q.push_back(e);
    end
    if (e_en) last_addr = e_addr;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      if (e.is_pix) begin e_pv = 1; m_pix = e.data; end
      else begin e_rv = e.mask; m_rd = e.data; end
    end
    m_gnt = e_gnt;
    chk("gnt", gnt, e_gnt);
    chk("rom_en", rom_en, e_en);
    chk("rom_addr", rom_addr, e_addr);
    chk("rd_valid", rd_valid, e_rv);
    chk("pix_valid", pix_valid, e_pv);
    chk("pix_data", pix_data, m_pix);
    chk("rd_data", rd_data, m_rd);
    if (p_tick && !prev_pt) anchor = cyc + 1;
    prev_pt = p_tick;
    cyc++;
  endtask

  // Driver: one clock, staged inputs applied after the edge, checks at negedge
  task automatic tick();
    @(posedge clk);
    #1;
    ptc = (ptc + 1) % 4;
    p_tick = (ptc < 2);
    reset = nx_reset;
    video_on = nx_video_on;
    pixel_x = nx_px;
    pixel_y = nx_py;
    req = nx_req;
    req0_addr = nx_a0;
    req1_addr = nx_a1;
    @(negedge clk);
    check_cycle();
  endtask

  typedef struct {
    logic [9:0]  px;
    logic [9:0]  py;
    bit          in_img;
    logic [14:0] addr;
    logic [7:0]  pix;
  } disp_vec_t;
  disp_vec_t vtab[7];

  initial begin
    int fetch_cnt, pv_cnt, g0, g1, last_w, got, rv_cnt;
    int last_g[2];
    logic [14:0] fa;

    vtab[0] = '{10'd8,   10'd4,   1'b1, 15'd162,   8'hA2};
    vtab[1] = '{10'd0,   10'd0,   1'b1, 15'd0,     8'h00};
    vtab[2] = '{10'd639, 10'd479, 1'b1, 15'd19199, 8'hFF};
    vtab[3] = '{10'd640, 10'd0,   1'b0, 15'd0,     8'h00};
    vtab[4] = '{10'd4,   10'd480, 1'b0, 15'd0,     8'h00};
    vtab[5] = '{10'd636, 10'd0,   1'b1, 15'd159,   8'h9F};
    vtab[6] = '{10'd100, 10'd200, 1'b1, 15'd8025,  8'h59};

    // 1. reset held with p_tick toggling, then idle release
    #2 reset = 1'b0;
    repeat (5) tick();
    nx_reset = 1'b1;
    repeat (3) tick();
    chk("idle_rom_en", rom_en, 0);
    chk("idle_gnt", gnt, 0);
    chk("idle_rd_valid", rd_valid, 0);
    chk("idle_pix_valid", pix_valid, 0);
    chk("idle_pix_data", pix_data, 8'h00);

    // 2/3. display fetch vectors, in and out of the image
    nx_video_on = 1'b1;
    nx_req = 2'b00;
    for (int v = 0; v < 7; v++) begin
      nx_px = vtab[v].px;
      nx_py = vtab[v].py;
      repeat (4) tick();
      fetch_cnt = 0; pv_cnt = 0; fa = '0;
      for (int c = 0; c < 8; c++) begin
        tick();
        if (rom_en) begin fetch_cnt++; fa = rom_addr; end
        if (pix_valid) pv_cnt++;
      end
      chk($sformatf("vec%0d_fetches", v), fetch_cnt, vtab[v].in_img ? 2 : 0);
      chk($sformatf("vec%0d_pix_valids", v), pv_cnt, 2);
      if (vtab[v].in_img) chk($sformatf("vec%0d_addr", v), fa, vtab[v].addr);
      chk($sformatf("vec%0d_pix", v), pix_data, vtab[v].pix);
    end

    // 4. contention during active video
    nx_px = 10'd8; nx_py = 10'd4;
    nx_a0 = 15'h1234; nx_a1 = 15'h0ABC;
    nx_req = 2'b11;
    g0 = 0; g1 = 0; last_w = -1; last_g[0] = -1; last_g[1] = -1;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (gnt != 2'b00) begin
        got = gnt[1] ? 1 : 0;
        if (last_w >= 0) chk("contention_alternate", got, 1 - last_w);
        if (last_g[got] >= 0) chk("contention_gap_le4", (c - last_g[got]) <= 4, 1);
        last_g[got] = c;
        last_w = got;
        if (got == 1) g1++; else g0++;
      end
      if (rd_valid == 2'b01) chk("contention_rd0_data", rd_data, 8'h34);
      if (rd_valid == 2'b10) chk("contention_rd1_data", rd_data, 8'hBC);
    end
    chk("contention_g0_count", g0, 9);
    chk("contention_g1_count", g1, 9);

    // 5. blanking throughput
    nx_req = 2'b00; nx_video_on = 1'b0;
    repeat (3) tick();
    nx_req = 2'b01;
    g0 = 0; rv_cnt = 0;
    for (int c = 0; c < 11; c++) begin
      nx_a0 = 15'($urandom_range(0, 32767));
      if (c == 8) nx_req = 2'b00;
      tick();
      if (gnt == 2'b01) g0++;
      if (rd_valid == 2'b01) rv_cnt++;
    end
    chk("blank_gnt0_count", g0, 8);
    chk("blank_rd0_count", rv_cnt, 8);

    // 6. reset one clock after a grant
    nx_req = 2'b01; nx_a0 = 15'h0055;
    got = 0;
    for (int c = 0; c < 8 && got == 0; c++) begin
      tick();
      if (gnt == 2'b01) got = 1;
    end
    chk("midreset_grant_seen", got, 1);
    nx_req = 2'b00;
    nx_reset = 1'b0;
    repeat (3) tick();
    nx_reset = 1'b1;
    rv_cnt = 0;
    repeat (5) begin
      tick();
      if (rd_valid != 2'b00) rv_cnt++;
    end
    chk("midreset_no_rd_valid", rv_cnt, 0);
    nx_req = 2'b11; nx_a1 = 15'h0077;
    nx_reset = 1'b0;
    repeat (2) tick();
    nx_reset = 1'b1;
    got = 0; fa = '0;
    for (int c = 0; c < 4 && got == 0; c++) begin
      tick();
      if (gnt != 2'b00) begin got = 1; fa = 15'(gnt); end
    end
    chk("midreset_first_grant_seen", got, 1);
    chk("midreset_first_grant_req0", fa, 15'd1);

    // Randomized run against the reference model
    nx_req = 2'b00;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 63) == 0) nx_video_on = ~nx_video_on;
      if ($urandom_range(0, 3) == 0) begin
        nx_px = 10'($urandom_range(0, 799));
        nx_py = 10'($urandom_range(0, 524));
      end
      for (int i = 0; i < 2; i++) begin
        if (nx_req[i]) begin
          if (m_gnt[i]) begin
            nx_req[i] = ($urandom_range(0, 1) == 1);
            if (i == 0) nx_a0 = 15'($urandom_range(0, 32767));
            else nx_a1 = 15'($urandom_range(0, 32767));
          end else if ($urandom_range(0, 15) == 0) begin
            nx_req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          nx_req[i] = 1'b1;
          if (i == 0) nx_a0 = 15'($urandom_range(0, 32767));
          else nx_a1 = 15'($urandom_range(0, 32767));
        end
      end
      nx_reset = ($urandom_range(0, 499) != 0);
      tick();
    end
    nx_reset = 1'b1;
    nx_req = 2'b00;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_rom_scheduler.md
Name: vga_rom_scheduler

Overview:
Time-slot scheduler that shares one synchronous image ROM between the VGA display path and two game-logic requesters (collision checker and scare engine). It sits between the VGA sync generator (p_tick, video_on, pixel_x, pixel_y) and the ROM. The display fetch is guaranteed one slot per pixel period during active video. All other cycles are round-robin arbitrated between the game requesters.

Parameters:
ADDR_W, 15, ROM address width
DATA_W, 8, ROM word / pixel colour width
IMG_W, 160, stored image width in pixels
IMG_H, 120, stored image height in pixels
SCALE_SHIFT, 2, screen-to-image downscale (pixel_x>>SCALE_SHIFT)
DISP_SLOT, 1, slot index reserved for the display fetch
BG_COLOR, 8'h00, colour output outside the image area

Ports:
clk in 1 system clock (100 MHz)
reset in 1 asynchronous, active-low reset
p_tick in 1 25 MHz pixel tick from the sync generator (2 clk high, 2 clk low)
video_on in 1 active-video flag
pixel_x in 10 current pixel column
pixel_y in 10 current pixel row
req in 2 game read request, one bit per requester
req0_addr in ADDR_W requester 0 address
req1_addr in ADDR_W requester 1 address
gnt out 2 one-cycle grant pulse per requester
rd_valid out 2 one-cycle read-data-valid pulse per requester
rd_data out DATA_W game read data, shared
rom_en out 1 ROM read enable
rom_addr out ADDR_W ROM address
rom_data in DATA_W ROM output, valid 1 clk after rom_en
pix_data out DATA_W registered pixel colour to the RGB stage
pix_valid out 1 one-cycle pulse when pix_data is updated

Behaviour:
- Reset (reset=0, async): all outputs 0, pix_data=BG_COLOR, slot=0, rr_ptr=0, p_tick delay reg=0, in-flight read pipeline cleared. Reset asserted mid-read drops that read; no rd_valid or pix_valid follows the reset release.
- Slot counter (2 bit): pix_start = p_tick & ~p_tick_d. On pix_start, slot<=0. Otherwise slot increments mod 4. Each pixel period therefore has slots 0..3.
- Issue rule, evaluated every clk, at most one ROM read per clk, priority as listed:
  1. slot==DISP_SLOT and video_on: display fetch. ix=pixel_x>>SCALE_SHIFT, iy=pixel_y>>SCALE_SHIFT.
     - If ix<IMG_W and iy<IMG_H: rom_en=1, rom_addr=iy*IMG_W+ix, truncated to ADDR_W. IMG_W is constant, so this is a constant multiply.
     - Else: rom_en=0, and pix_data<=BG_COLOR with pix_valid=1 two clks later, keeping the same latency as a real fetch.
  2. Otherwise, if req!=0: grant one requester. If both request, grant req[rr_ptr]. Assert gnt[i] that clk, rom_en=1, rom_addr=reqi_addr. rr_ptr<=~i.
  3. Otherwise rom_en=0 and rom_addr holds its last value.
- When the display slot coincides with pending requests, display wins, gnt=0 that clk, and rr_ptr is unchanged.
- During blanking (video_on=0), all 4 slots go to game requesters.
- Latency:
  - ROM data arrives at issue+1.
  - rd_data/rd_valid[i] are registered at issue+2.
  - pix_data/pix_valid are registered at issue+2.
  - rd_data holds its value until the next game read.
  - pix_data holds its value until the next display fetch.
- Requester protocol:
  - Requester holds req[i]=1 with a stable address until it sees gnt[i].
  - Requester may deassert req in the gnt cycle or keep it high for back-to-back reads.
  - A req dropped before grant is simply not served.
  - Exactly one rd_valid[i] follows each gnt[i].
- Fairness bound: with both requesters continuously active during active video, each is granted at least once every 4 clks. Worst-case wait from req to gnt is 3 clks.
- Pipeline: a 2-deep valid/tag shift register with tag {disp, req0, req1} steers rom_data. There is no FIFO and no back-pressure; requesters must accept rd_valid when it pulses.

Test Plan:
1. Reset and idle: hold reset=0 for 5 clks with p_tick toggling, then release with req=0 and video_on=0 -> rom_en=0, gnt=0, rd_valid=0, pix_valid=0, pix_data=8'h00.
2. Display fetch: video_on=1, pixel_x=8, pixel_y=4, ROM model returns addr[7:0] -> rom_en with rom_addr=1*160+2=162 in slot 1; pix_data=8'hA2 and pix_valid=1 two clks later; exactly one fetch per 4 clks.
3. Out-of-image: pixel_x=640, or set IMG_H small and pixel_y beyond it -> no rom_en in slot 1; pix_data=BG_COLOR with pix_valid at issue+2.
4. Contention: video_on=1, req=2'b11 held continuously -> grant order alternates 0,1,0,1; no gnt in slot 1; each requester is granted ≥1 per 4 clks; each rd_valid[i] arrives 2 clks after its gnt[i] with data = its address LSBs.
5. Blanking throughput: video_on=0, req=2'b01 held for 8 clks -> 8 consecutive gnt[0] pulses, 8 rd_valid[0] pulses at 2-clk latency.
6. Reset mid-operation: assert reset one clk after gnt[0] -> no rd_valid[0] after reset release; rr_ptr=0, so the first grant with req=2'b11 goes to requester 0.
